// File: rtl/uart_tx_framer.sv
// UART transmit framer: small word FIFO feeding a start/data/parity/stop
// serialiser with a registered serial output.
module uart_tx_framer #(
    parameter int CLK_DIV    = 1250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_txd,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int STOP_LEN = STOP_BITS * CLK_DIV;
    localparam int TW       = $clog2(STOP_LEN);
    localparam int BCW      = $clog2(DATA_BITS);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("uart_tx_framer: CLK_DIV must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx_framer: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_tx_framer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_framer: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;

    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  start_frame;
    logic                  timer_end;
    logic                  stop_end;
    logic [DATA_BITS-1:0]  head;
    logic                  head_par;

    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign push      = i_valid && !full;
    assign head      = mem_q[rd_ptr_q];
    assign head_par  = (PARITY == 1) ? ~(^head) : (^head);
    assign timer_end = (timer_q == TW'(CLK_DIV - 1));
    assign stop_end  = (timer_q == TW'(STOP_LEN - 1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        txd_d       = txd_q;
        pop         = 1'b0;
        start_frame = 1'b0;

        if (state_q != IDLE) begin
            timer_d = timer_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                txd_d   = 1'b1;
                timer_d = '0;
                if (level_q != '0) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (timer_end) begin
                    state_d   = DATA;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            DATA: begin
                if (timer_end) begin
                    timer_d = '0;
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            state_d = PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                if (timer_end) begin
                    state_d = STOP;
                    timer_d = '0;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (stop_end) begin
                    timer_d = '0;
                    if (level_q != '0) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                txd_d   = 1'b1;
            end
        endcase

        // Loading the head here lets a queued word follow STOP with no gap.
        if (start_frame) begin
            pop       = 1'b1;
            shift_d   = head;
            par_d     = head_par;
            timer_d   = '0;
            bit_cnt_d = '0;
            state_d   = START;
            txd_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_ready = !full;
    assign o_txd   = txd_q;
    assign o_busy  = (state_q != IDLE);
    assign o_level = level_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four parameterisations sharing
// clock and reset, checked with immediate assertions at each step.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] valid = 4'h0;
    logic [3:0] ready;
    logic [3:0] txd;
    logic [3:0] busy;
    logic [2:0] lvl [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // default configuration
    uart_tx_framer u_a (
        .clk(clk), .rst(rst), .i_data(din), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_txd(txd[0]), .o_busy(busy[0]), .o_level(lvl[0])
    );

    // fast, even parity
    uart_tx_framer #(.CLK_DIV(4), .PARITY(2)) u_b (
        .clk(clk), .rst(rst), .i_data(din), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_txd(txd[1]), .o_busy(busy[1]), .o_level(lvl[1])
    );

    // fast, odd parity
    uart_tx_framer #(.CLK_DIV(4), .PARITY(1)) u_c (
        .clk(clk), .rst(rst), .i_data(din), .i_valid(valid[2]),
        .o_ready(ready[2]), .o_txd(txd[2]), .o_busy(busy[2]), .o_level(lvl[2])
    );

    // fast, 7 data bits, 2 stop bits
    uart_tx_framer #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst), .i_data(din[6:0]), .i_valid(valid[3]),
        .o_ready(ready[3]), .o_txd(txd[3]), .o_busy(busy[3]), .o_level(lvl[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Push one word into instance s, then follow the frame bit by bit.
    task automatic run_frame(input int s, input logic [7:0] w, input int div,
                             input int nb, input logic [15:0] bits,
                             input string tag);
        din      = w;
        valid[s] = 1'b1;
        @(negedge clk);
        valid[s] = 1'b0;
        chk($sformatf("%s_lvl_push", tag), 32'(lvl[s]), 1);
        chk($sformatf("%s_txd_pre", tag), 32'(txd[s]), 1);
        for (int t = 0; t < nb * div; t++) begin
            @(negedge clk);
            if (t % div == 0 || t % div == div - 1) begin
                chk($sformatf("%s_bit%0d_c%0d", tag, t / div, t % div),
                    32'(txd[s]), 32'(bits[t / div]));
                chk($sformatf("%s_busy_c%0d", tag, t), 32'(busy[s]), 1);
            end
        end
        @(negedge clk);
        chk($sformatf("%s_txd_end", tag), 32'(txd[s]), 1);
        chk($sformatf("%s_busy_end", tag), 32'(busy[s]), 0);
        chk($sformatf("%s_lvl_end", tag), 32'(lvl[s]), 0);
    endtask

    initial begin
        int         acc;
        int         t;
        int         f;
        int         b;
        logic       v;
        logic       e;
        logic [7:0] wv;
        logic [10:0] fr;
        logic [5:0] par_t;
        int         lv_t [8];

        par_t = 6'b010110;
        lv_t  = '{1, 1, 2, 3, 4, 4, 4, 4};

        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("rst_txd%0d", s), 32'(txd[s]), 1);
            chk($sformatf("rst_busy%0d", s), 32'(busy[s]), 0);
            chk($sformatf("rst_lvl%0d", s), 32'(lvl[s]), 0);
            chk($sformatf("rst_rdy%0d", s), 32'(ready[s]), 1);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_txd_b", 32'(txd[1]), 1);
        chk("idle_busy_b", 32'(busy[1]), 0);

        run_frame(0, 8'h61, 1250, 10, 16'h02C2, "def61");
        run_frame(2, 8'h61, 4, 11, 16'h04C2, "odd61");
        run_frame(1, 8'h61, 4, 11, 16'h06C2, "even61");
        run_frame(3, 8'h55, 4, 10, 16'h03AA, "d7s2_55");

        // Burst into a full FIFO, then a refused push on a pop edge.
        acc = 0;
        for (int j = 1; j <= 272; j++) begin
            v = (j <= 8) || (j == 46) || (j == 47);
            if (j <= 8) din = 8'hA0 + 8'(j - 1);
            else if (j == 46) din = 8'hB5;
            else din = 8'hC6;
            valid[1] = v;
            if (j <= 8) chk($sformatf("burst_rdy_j%0d", j), 32'(ready[1]),
                            32'(j <= 5));
            if (j == 46) chk("full_pop_rdy", 32'(ready[1]), 0);
            if (j == 47) chk("after_pop_rdy", 32'(ready[1]), 1);
            if (v && ready[1]) acc++;
            @(negedge clk);
            valid[1] = 1'b0;
            if (j <= 8) chk($sformatf("burst_lvl_j%0d", j), 32'(lvl[1]),
                            32'(lv_t[j - 1]));
            if (j == 8) chk("burst_accepted", 32'(acc), 5);
            if (j == 46) chk("full_pop_lvl", 32'(lvl[1]), 3);
            if (j == 47) chk("after_pop_lvl", 32'(lvl[1]), 4);
            t = j - 2;
            if (t >= 0 && t < 264) begin
                f  = t / 44;
                b  = (t % 44) / 4;
                wv = (f < 5) ? 8'hA0 + 8'(f) : 8'hC6;
                fr = {1'b1, par_t[f], wv, 1'b0};
                e  = fr[b];
            end else begin
                e = 1'b1;
            end
            if (t < 0 || t % 4 == 0 || t % 4 == 3)
                chk($sformatf("burst_txd_t%0d", t), 32'(txd[1]), 32'(e));
        end
        chk("burst_total_acc", 32'(acc), 6);
        chk("burst_busy_end", 32'(busy[1]), 0);
        chk("burst_lvl_end", 32'(lvl[1]), 0);

        // Reset in the third data bit with two words still queued.
        for (int j = 1; j <= 3; j++) begin
            din      = 8'(17 * j);
            valid[1] = 1'b1;
            @(negedge clk);
        end
        valid[1] = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst_busy", 32'(busy[1]), 1);
        chk("pre_rst_lvl", 32'(lvl[1]), 2);
        chk("pre_rst_txd_d2", 32'(txd[1]), 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_txd", 32'(txd[1]), 1);
        chk("mid_rst_lvl", 32'(lvl[1]), 0);
        chk("mid_rst_busy", 32'(busy[1]), 0);
        chk("mid_rst_rdy", 32'(ready[1]), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_txd_c%0d", c), 32'(txd[1]), 1);
        end
        chk("post_rst_busy", 32'(busy[1]), 0);
        chk("post_rst_lvl", 32'(lvl[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
